// File: rtl/irq_controller.sv
// Purpose : 8-source edge-triggered interrupt controller with mask, fixed priority
//           arbitration (bit 7 highest) and a req/ack/eoi handshake to the core.
// Latency : irq_in rise sampled at edge E0 -> pending at E0 -> irq_req high after E1.
// Backpressure: one request outstanding at a time; new events queue in pending
//           until the current request has been acked and closed with eoi.
//
// Ports:
//   clk        in   clock, rising edge
//   rstN       in   asynchronous active-low reset
//   irq_in     in   interrupt sources, synchronous to clk, rising-edge triggered
//   int_en     in   global interrupt enable (status[7])
//   mask_wr    in   load mask register from mask_data
//   mask_data  in   new mask value, 1 = source masked
//   irq_ack    in   core accepts the presented request (pulse)
//   eoi        in   core finished servicing (pulse)
//   irq_req    out  request to the core
//   irq_id     out  id of the presented / in-service source
//   in_service out  request acked, awaiting eoi
//   pending    out  raw pending register (mask not applied)
//   timeout    out  sticky ack-timeout flag
//
// Build option: define IRQ_TIMEOUT_EN to withdraw an un-acked request after
// ACK_TIMEOUT cycles and flag it on timeout. Without it, REQ waits indefinitely
// and timeout is constant 0.

module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int ID_W        = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_en,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout
);

    // The downstream 8-to-3 encoder fixes the geometry; refuse anything else.
    generate
        if (NUM_IRQ != 8 || ID_W != 3 || ACK_TIMEOUT < 1) begin : g_bad_cfg
            $error("irq_controller: unsupported NUM_IRQ/ID_W/ACK_TIMEOUT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic               irq_req_q;
    logic [ID_W-1:0]    irq_id_q;
    logic               in_service_q;

    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               any_eligible;
    logic               ack_take;

    // ------------------------------------------------------------------
    // Edge capture and pending register
    // ------------------------------------------------------------------
    assign rise     = irq_in & ~irq_prev_q;
    assign ack_take = (state_q == ST_REQ) && irq_ack;

    always_comb begin
        clr = '0;
        if (ack_take) begin
            clr[irq_id_q] = 1'b1;
        end
        // Set is applied after clear so a fresh edge on the acked source
        // in the same cycle is not lost.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        mask_d = mask_q;
        if (mask_wr) begin
            mask_d = mask_data;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Fixed-priority arbitration: scanning upwards lets the highest set
    // bit overwrite lower ones, matching the encoder's ordering.
    // ------------------------------------------------------------------
    assign eligible     = pending_q & ~mask_q;
    assign any_eligible = |eligible;

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM with registered outputs
    // ------------------------------------------------------------------
`ifdef IRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout_q;
    logic             to_expire;

    // Expiry marks the ACK_TIMEOUT-th cycle spent in REQ.
    assign to_expire = (to_cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (int_en && any_eligible) begin
                        state_q   <= ST_REQ;
                        irq_req_q <= 1'b1;
                        irq_id_q  <= winner;
`ifdef IRQ_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                end

                // Once presented, the request is frozen: mask, int_en and
                // higher-priority arrivals are only looked at again in IDLE.
                ST_REQ: begin
                    if (irq_ack) begin
                        state_q      <= ST_SERVICE;
                        irq_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end
`ifdef IRQ_TIMEOUT_EN
                    // pending is left set so the source is re-arbitrated.
                    else if (to_expire) begin
                        state_q   <= ST_IDLE;
                        irq_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
`endif
                end

                // No nesting: nothing new is presented until eoi.
                ST_SERVICE: begin
                    if (eoi) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end

                default: begin
                    state_q      <= ST_IDLE;
                    irq_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

`ifdef IRQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: drives inputs 1 time unit after each
// rising edge and samples outputs at the same point, before new inputs apply.

module tb_irq_controller;

    localparam int TO_CYC = 16;

    logic       clk;
    logic       rstN;
    logic [7:0] irq_in;
    logic       int_en;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic       irq_ack;
    logic       eoi;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       in_service;
    logic [7:0] pending;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    irq_controller #(
        .NUM_IRQ    (8),
        .ID_W       (3),
        .ACK_TIMEOUT(TO_CYC)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .irq_in     (irq_in),
        .int_en     (int_en),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .irq_ack    (irq_ack),
        .eoi        (eoi),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        tick();
        mask_wr   = 1'b0;
    endtask

    // Hard stop in case something blocks unexpectedly.
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN      = 1'b0;
        irq_in    = 8'h00;
        int_en    = 1'b0;
        mask_wr   = 1'b0;
        mask_data = 8'h00;
        irq_ack   = 1'b0;
        eoi       = 1'b0;
        tick();
        tick();
        chk("rst_req",     32'(irq_req),    32'h0);
        chk("rst_id",      32'(irq_id),     32'h0);
        chk("rst_insvc",   32'(in_service), 32'h0);
        chk("rst_pending", 32'(pending),    32'h00);
        chk("rst_timeout", 32'(timeout),    32'h0);
        rstN = 1'b1;
        tick();

        // Reset mask is all-ones: event is captured but not requested.
        int_en = 1'b1;
        pulse(8'h01);
        chk("rstmask_pend", 32'(pending), 32'h01);
        tick();
        tick();
        chk("rstmask_noreq", 32'(irq_req), 32'h0);
        set_mask(8'h00);
        chk("maskwr_lat", 32'(irq_req), 32'h0);
        tick();
        chk("unmask_req", 32'(irq_req), 32'h1);
        chk("unmask_id",  32'(irq_id),  32'h0);
        do_ack();
        do_eoi();

        // Single source 3, latency, ignored eoi in REQ / ack in SERVICE.
        pulse(8'h08);
        chk("s3_pend",  32'(pending), 32'h08);
        chk("s3_noreq", 32'(irq_req), 32'h0);
        tick();
        chk("s3_req", 32'(irq_req), 32'h1);
        chk("s3_id",  32'(irq_id),  32'h3);
        do_eoi();
        chk("s3_eoi_ign_req",   32'(irq_req),    32'h1);
        chk("s3_eoi_ign_insvc", 32'(in_service), 32'h0);
        do_ack();
        chk("s3_ack_insvc", 32'(in_service), 32'h1);
        chk("s3_ack_req",   32'(irq_req),    32'h0);
        chk("s3_ack_pend",  32'(pending),    32'h00);
        chk("s3_ack_id",    32'(irq_id),     32'h3);
        do_ack();
        chk("s3_ack_ign", 32'(in_service), 32'h1);
        do_eoi();
        chk("s3_eoi_insvc", 32'(in_service), 32'h0);
        chk("s3_eoi_req",   32'(irq_req),    32'h0);

        // Simultaneous 5 and 2: 5 first, then 2 after one idle cycle.
        pulse(8'h24);
        chk("p24_pend", 32'(pending), 32'h24);
        tick();
        chk("p24_id5", 32'(irq_id), 32'h5);
        do_ack();
        chk("p24_pend_after5", 32'(pending), 32'h04);
        do_eoi();
        chk("p24_idle_gap", 32'(irq_req), 32'h0);
        tick();
        chk("p24_req2", 32'(irq_req), 32'h1);
        chk("p24_id2",  32'(irq_id),  32'h2);
        do_ack();
        chk("p24_pend_end", 32'(pending), 32'h00);
        do_eoi();

        // Held-high source raises only one event.
        irq_in = 8'h02;
        tick();
        tick();
        chk("hold_id1", 32'(irq_id), 32'h1);
        do_ack();
        do_eoi();
        tick();
        chk("hold_noreq",  32'(irq_req), 32'h0);
        chk("hold_nopend", 32'(pending), 32'h00);
        irq_in = 8'h00;
        tick();
        pulse(8'h02);
        chk("hold_repend", 32'(pending), 32'h02);
        tick();
        chk("hold_rereq", 32'(irq_req), 32'h1);
        do_ack();
        do_eoi();

        // Mask 0x80: only 1 served; 7 presented once unmasked.
        set_mask(8'h80);
        pulse(8'h82);
        chk("m80_pend", 32'(pending), 32'h82);
        tick();
        chk("m80_id1", 32'(irq_id), 32'h1);
        do_ack();
        chk("m80_pend_after", 32'(pending), 32'h80);
        do_eoi();
        tick();
        chk("m80_noreq7", 32'(irq_req), 32'h0);
        set_mask(8'h00);
        tick();
        chk("m80_req7", 32'(irq_req), 32'h1);
        chk("m80_id7",  32'(irq_id),  32'h7);
        do_ack();
        do_eoi();
        chk("m80_pend_end", 32'(pending), 32'h00);

        // Request for 4 is frozen against masking, int_en drop and priority.
        pulse(8'h10);
        tick();
        chk("frz_id4", 32'(irq_id), 32'h4);
        irq_in    = 8'h40;
        mask_wr   = 1'b1;
        mask_data = 8'h10;
        int_en    = 1'b0;
        tick();
        irq_in  = 8'h00;
        mask_wr = 1'b0;
        tick();
        chk("frz_req",  32'(irq_req), 32'h1);
        chk("frz_id",   32'(irq_id),  32'h4);
        chk("frz_pend", 32'(pending), 32'h50);
        int_en = 1'b1;
        do_ack();
        chk("frz_ack_pend", 32'(pending), 32'h40);
        do_eoi();
        tick();
        chk("frz_next_id6", 32'(irq_id),  32'h6);
        chk("frz_next_req", 32'(irq_req), 32'h1);
        do_ack();
        do_eoi();
        set_mask(8'h00);

        // int_en gating.
        int_en = 1'b0;
        pulse(8'h01);
        tick();
        tick();
        chk("ien_pend",  32'(pending), 32'h01);
        chk("ien_noreq", 32'(irq_req), 32'h0);
        int_en = 1'b1;
        tick();
        chk("ien_req", 32'(irq_req), 32'h1);
        chk("ien_id",  32'(irq_id),  32'h0);
        do_ack();
        do_eoi();

        // Fresh edge on the source being acked survives the clear.
        pulse(8'h04);
        tick();
        irq_in  = 8'h04;
        irq_ack = 1'b1;
        tick();
        irq_in  = 8'h00;
        irq_ack = 1'b0;
        chk("setwins_pend",  32'(pending),    32'h04);
        chk("setwins_insvc", 32'(in_service), 32'h1);
        do_eoi();
        tick();
        chk("setwins_rereq", 32'(irq_id),  32'h2);
        chk("setwins_req",   32'(irq_req), 32'h1);
        do_ack();
        do_eoi();

`ifdef IRQ_TIMEOUT_EN
        pulse(8'h08);
        tick();
        chk("to_req", 32'(irq_req), 32'h1);
        for (int i = 0; i < TO_CYC - 1; i++) tick();
        chk("to_still_req", 32'(irq_req), 32'h1);
        chk("to_not_yet",   32'(timeout), 32'h0);
        tick();
        chk("to_drop",  32'(irq_req), 32'h0);
        chk("to_flag",  32'(timeout), 32'h1);
        chk("to_pend",  32'(pending), 32'h08);
        tick();
        chk("to_rereq", 32'(irq_req), 32'h1);
        chk("to_reid",  32'(irq_id),  32'h3);
        do_ack();
        do_eoi();
        chk("to_sticky", 32'(timeout), 32'h1);
`else
        pulse(8'h08);
        tick();
        for (int i = 0; i < TO_CYC + 4; i++) tick();
        chk("nto_hold_req", 32'(irq_req), 32'h1);
        chk("nto_flag",     32'(timeout), 32'h0);
        do_ack();
        do_eoi();
`endif

        // Asynchronous reset during service drops everything.
        pulse(8'h20);
        tick();
        do_ack();
        pulse(8'h02);
        rstN = 1'b0;
        #1;
        chk("arst_insvc", 32'(in_service), 32'h0);
        chk("arst_req",   32'(irq_req),    32'h0);
        chk("arst_pend",  32'(pending),    32'h00);
        chk("arst_to",    32'(timeout),    32'h0);
        #2;
        rstN = 1'b1;
        tick();
        pulse(8'h01);
        tick();
        tick();
        chk("arst_mask_ff", 32'(irq_req), 32'h0);
        chk("arst_pend1",   32'(pending), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
